// File: rtl/alu_exec_mc.sv
// alu_exec_mc: RISC-V style execute stage. Single-cycle ALU ops plus a
// multi-cycle multiply/divide unit (shift-add / restoring divide, one bit
// per cycle) behind a valid/ready handshake on both sides.
module alu_exec_mc #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      alu_op,
  input  logic [2:0]      funct3,
  input  logic [6:0]      funct7,
  input  logic [XLEN-1:0] src_a,
  input  logic [XLEN-1:0] src_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic [3:0]      alu_control,
  output logic            busy
);
  localparam int SW = $clog2(XLEN);
  localparam logic [SW-1:0]   CNT_LAST = SW'(XLEN - 1);
  localparam logic [XLEN-1:0] MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV, S_FIX, S_DONE} state_t;
  typedef enum logic [3:0] {
    C_ADD = 4'b0000, C_SUB = 4'b0001, C_SLL = 4'b0010, C_XOR  = 4'b0011,
    C_SRL = 4'b0100, C_SRA = 4'b0101, C_OR  = 4'b0110, C_AND  = 4'b0111,
    C_SLTU = 4'b1000, C_SLT = 4'b1001, C_MDU = 4'b1111
  } ctl_t;

  state_t          state;
  ctl_t            ctl_q;
  logic [SW-1:0]   cnt;
  logic [2:0]      f3_q;
  logic            neg_q;   // product / quotient must be negated in FIX
  logic            neg_r;   // remainder must be negated in FIX
  logic [XLEN-1:0] hi;      // product high half, or partial remainder
  logic [XLEN-1:0] lo;      // multiplier / product low half, or quotient
  logic [XLEN-1:0] opnd;    // multiplicand or divisor magnitude

  ctl_t            dec_ctl;
  logic [XLEN-1:0] alu_res;
  logic [SW-1:0]   shamt;

  assign in_ready    = (state == S_IDLE) && !out_valid;
  assign alu_control = ctl_q;
  assign shamt       = src_b[SW-1:0];

  // Decode alu_op/funct3/funct7 into the operation code.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    dec_ctl = C_ADD;
    unique case (alu_op)
      2'b00: dec_ctl = C_ADD;
      2'b11: dec_ctl = C_OR;
      2'b10: begin
        case (funct3)
          3'b000, 3'b001: dec_ctl = C_SUB;
          3'b100, 3'b101: dec_ctl = C_SLT;
          3'b110, 3'b111: dec_ctl = C_SLTU;
          default:        dec_ctl = C_ADD;
        endcase
      end
      2'b01: begin
        if (funct7 == 7'b0000001)  dec_ctl = C_MDU;
        else if (funct7[5])        dec_ctl = (funct3 == 3'b101) ? C_SRA : C_SUB;
        else begin
          case (funct3)
            3'b000:  dec_ctl = C_ADD;
            3'b001:  dec_ctl = C_SLL;
            3'b010:  dec_ctl = C_SLT;
            3'b011:  dec_ctl = C_SLTU;
            3'b100:  dec_ctl = C_XOR;
            3'b101:  dec_ctl = C_SRL;
            3'b110:  dec_ctl = C_OR;
            default: dec_ctl = C_AND;
          endcase
        end
      end
      default: dec_ctl = C_ADD;
    endcase
  end

  // Single-cycle ALU datapath.
  always_comb begin
    alu_res = '0;
    case (dec_ctl)
      C_ADD:   alu_res = src_a + src_b;
      C_SUB:   alu_res = src_a - src_b;
      C_SLL:   alu_res = src_a << shamt;
      C_XOR:   alu_res = src_a ^ src_b;
      C_SRL:   alu_res = src_a >> shamt;
      C_SRA:   alu_res = $unsigned($signed(src_a) >>> shamt);
      C_OR:    alu_res = src_a | src_b;
      C_AND:   alu_res = src_a & src_b;
      C_SLTU:  alu_res = XLEN'(src_a < src_b);
      C_SLT:   alu_res = XLEN'($signed(src_a) < $signed(src_b));
      default: alu_res = '0;
    endcase
  end

  // Which operands are signed for the requested MDU op.
  logic a_sgn, b_sgn;
  always_comb begin
    a_sgn = 1'b0;
    b_sgn = 1'b0;
    case (funct3)
      3'b001, 3'b100, 3'b110: begin a_sgn = 1'b1; b_sgn = 1'b1; end
      3'b010:                 a_sgn = 1'b1;
      default:                ;
    endcase
  end

  logic            a_neg, b_neg, div_zero, div_ovf;
  logic [XLEN-1:0] a_mag, b_mag, short_res;
  assign a_neg     = a_sgn && src_a[XLEN-1];
  assign b_neg     = b_sgn && src_b[XLEN-1];
  assign a_mag     = a_neg ? -src_a : src_a;
  assign b_mag     = b_neg ? -src_b : src_b;
  assign div_zero  = funct3[2] && (src_b == '0);
  assign div_ovf   = funct3[2] && !funct3[0] && (src_a == MIN_NEG) && (src_b == '1);
  // REM* yields the dividend (div by 0) or 0 (overflow); DIV* yields all-ones or the dividend.
  assign short_res = funct3[1] ? (div_zero ? src_a : '0) : (div_zero ? '1 : src_a);

  // One iteration step of each engine.
  logic [XLEN:0] mul_sum, rem_sh, rem_diff;
  assign mul_sum  = {1'b0, hi} + (lo[0] ? {1'b0, opnd} : '0);
  assign rem_sh   = {hi, lo[XLEN-1]};
  assign rem_diff = rem_sh - {1'b0, opnd};

  // Sign correction and half selection applied in FIX.
  logic [2*XLEN-1:0] mul_full, mul_fixed;
  logic [XLEN-1:0]   fix_res;
  assign mul_full  = {hi, lo};
  assign mul_fixed = neg_q ? -mul_full : mul_full;
  always_comb begin
    fix_res = '0;
    if (!f3_q[2])    fix_res = (f3_q[1:0] == 2'b00) ? mul_fixed[XLEN-1:0] : mul_fixed[2*XLEN-1:XLEN];
    else if (f3_q[1]) fix_res = neg_r ? -hi : hi;
    else              fix_res = neg_q ? -lo : lo;
  end

  // Control FSM and registered datapath/outputs.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!rst_n) begin
      state     <= S_IDLE;
      ctl_q     <= C_ADD;
      cnt       <= '0;
      f3_q      <= '0;
      neg_q     <= 1'b0;
      neg_r     <= 1'b0;
      hi        <= '0;
      lo        <= '0;
      opnd      <= '0;
      result    <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          cnt <= '0;
          if (in_valid && in_ready) begin
            ctl_q <= dec_ctl;
            f3_q  <= funct3;
            neg_q <= a_neg ^ b_neg;
            neg_r <= a_neg;
            hi    <= '0;
            if (dec_ctl != C_MDU) begin
              result    <= alu_res;
              out_valid <= 1'b1;
              state     <= S_DONE;
            end else if (div_zero || div_ovf) begin
              result    <= short_res;
              out_valid <= 1'b1;
              state     <= S_DONE;
            end else if (funct3[2]) begin
              lo    <= a_mag;
              opnd  <= b_mag;
              busy  <= 1'b1;
              state <= S_DIV;
            end else begin
              lo    <= b_mag;
              opnd  <= a_mag;
              busy  <= 1'b1;
              state <= S_MUL;
            end
          end
        end
        S_MUL: begin
          hi  <= mul_sum[XLEN:1];
          lo  <= {mul_sum[0], lo[XLEN-1:1]};
          cnt <= cnt + 1'b1;
          if (cnt == CNT_LAST) state <= S_FIX;
        end
        S_DIV: begin
          if (!rem_diff[XLEN]) begin
            hi <= rem_diff[XLEN-1:0];
            lo <= {lo[XLEN-2:0], 1'b1};
          end else begin
            hi <= rem_sh[XLEN-1:0];
            lo <= {lo[XLEN-2:0], 1'b0};
          end
          cnt <= cnt + 1'b1;
          if (cnt == CNT_LAST) state <= S_FIX;
        end
        S_FIX: begin
          result    <= fix_res;
          out_valid <= 1'b1;
          busy      <= 1'b0;
          state     <= S_DONE;
        end
        S_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_exec_mc.sv
// tb_alu_exec_mc: directed vector table, hand-written multi-cycle corner
// sequences and randomized ops against an arithmetic reference model.
module tb_alu_exec_mc;
  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            in_valid;
  logic            in_ready;
  logic [1:0]      alu_op;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  logic [XLEN-1:0] src_a;
  logic [XLEN-1:0] src_b;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;
  logic [3:0]      alu_control;
  logic            busy;

  int n_tests = 0;
  int n_fail  = 0;

  alu_exec_mc #(.XLEN(XLEN)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .alu_op(alu_op), .funct3(funct3), .funct7(funct7), .src_a(src_a), .src_b(src_b),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .alu_control(alu_control), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  typedef struct {
    string       name;
    logic [1:0]  op;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic [3:0]  ctl;
    int          lat;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: decode rules plus 64-bit arithmetic.
  function automatic void model(input logic [1:0] op, input logic [2:0] f3, input logic [6:0] f7,
                                input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] res, output logic [3:0] ctl, output int lat);
    longint      sa, sb, ua, ub;
    logic [63:0] p;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    ua  = longint'({32'd0, a});
    ub  = longint'({32'd0, b});
    lat = 1;
    res = '0;
    case (op)
      2'd0: ctl = 4'b0000;
      2'd3: ctl = 4'b0110;
      2'd2: ctl = (f3 < 3'd2) ? 4'b0001 : (f3 < 3'd6) ? 4'b1001 : 4'b1000;
      default: begin
        if (f7 == 7'd1)   ctl = 4'b1111;
        else if (f7[5])   ctl = (f3 == 3'd5) ? 4'b0101 : 4'b0001;
        else begin
          case (f3)
            3'd0: ctl = 4'b0000;  3'd1: ctl = 4'b0010;
            3'd2: ctl = 4'b1001;  3'd3: ctl = 4'b1000;
            3'd4: ctl = 4'b0011;  3'd5: ctl = 4'b0100;
            3'd6: ctl = 4'b0110;  default: ctl = 4'b0111;
          endcase
        end
      end
    endcase
    case (ctl)
      4'b0000: res = a + b;
      4'b0001: res = a - b;
      4'b0010: res = a << b[4:0];
      4'b0011: res = a ^ b;
      4'b0100: res = a >> b[4:0];
      4'b0101: begin p = 64'(sa >>> b[4:0]); res = p[31:0]; end
      4'b0110: res = a | b;
      4'b0111: res = a & b;
      4'b1000: res = (ua < ub) ? 32'd1 : 32'd0;
      4'b1001: res = (sa < sb) ? 32'd1 : 32'd0;
      default: begin
        lat = 34;
        case (f3)
          3'd0: begin p = 64'(sa * sb); res = p[31:0];  end
          3'd1: begin p = 64'(sa * sb); res = p[63:32]; end
          3'd2: begin p = 64'(sa * ub); res = p[63:32]; end
          3'd3: begin p = 64'(ua * ub); res = p[63:32]; end
          default: begin
            if (b == 0) begin
              lat = 1;
              res = f3[1] ? a : 32'hFFFF_FFFF;
            end else if (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
              lat = 1;
              res = f3[1] ? 32'd0 : a;
            end else if (!f3[0]) begin
              p = 64'(f3[1] ? (sa % sb) : (sa / sb)); res = p[31:0];
            end else begin
              p = 64'(f3[1] ? (ua % ub) : (ua / ub)); res = p[31:0];
            end
          end
        endcase
      end
    endcase
  endfunction

  // Offer one op at a negedge, then wait (bounded) for out_valid; no handshake.
  task automatic run_op(input string name, input logic [1:0] op, input logic [2:0] f3,
                        input logic [6:0] f7, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res, output logic [3:0] ctl,
                        output int lat, output int busy_cnt);
    check({name, "_in_ready"}, 64'(in_ready), 64'd1);
    alu_op = op; funct3 = f3; funct7 = f7; src_a = a; src_b = b;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    alu_op = 2'($urandom); funct3 = 3'($urandom); funct7 = 7'($urandom);
    src_a = $urandom; src_b = $urandom;
    lat = 1;
    busy_cnt = 0;
    while (!out_valid && lat < 100) begin
      if (busy) busy_cnt++;
      @(negedge clk);
      lat++;
    end
    res = result;
    ctl = alu_control;
  endtask

  task automatic ack(input string name);
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check({name, "_out_valid_low"}, 64'(out_valid), 64'd0);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0:       return 32'd0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    vec_t        vecs[$];
    logic [31:0] r, mr;
    logic [3:0]  c, mc;
    int          lat, mlat, bcnt;
    logic [1:0]  op;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] a, b;

    vecs.push_back('{"add",     2'b00, 3'd0, 7'h00, 32'd5,          32'd7,          32'd12,         4'b0000, 1});
    vecs.push_back('{"sra",     2'b01, 3'd5, 7'h20, 32'h8000_0000,  32'd4,          32'hF800_0000,  4'b0101, 1});
    vecs.push_back('{"mulh",    2'b01, 3'd1, 7'h01, 32'hFFFF_FFFF,  32'd2,          32'hFFFF_FFFF,  4'b1111, 34});
    vecs.push_back('{"div0",    2'b01, 3'd4, 7'h01, 32'd100,        32'd0,          32'hFFFF_FFFF,  4'b1111, 1});
    vecs.push_back('{"rem0",    2'b01, 3'd6, 7'h01, 32'd100,        32'd0,          32'd100,        4'b1111, 1});
    vecs.push_back('{"divovf",  2'b01, 3'd4, 7'h01, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  4'b1111, 1});
    vecs.push_back('{"removf",  2'b01, 3'd6, 7'h01, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          4'b1111, 1});
    vecs.push_back('{"divu0",   2'b01, 3'd5, 7'h01, 32'hFFFF_FFFF,  32'd0,          32'hFFFF_FFFF,  4'b1111, 1});
    vecs.push_back('{"remu0",   2'b01, 3'd7, 7'h01, 32'd7,          32'd0,          32'd7,          4'b1111, 1});
    vecs.push_back('{"bsub",    2'b10, 3'd0, 7'h00, 32'd3,          32'd5,          32'hFFFF_FFFE,  4'b0001, 1});
    vecs.push_back('{"bslt",    2'b10, 3'd4, 7'h00, 32'hFFFF_FFFF,  32'd1,          32'd1,          4'b1001, 1});
    vecs.push_back('{"bsltu",   2'b10, 3'd6, 7'h00, 32'hFFFF_FFFF,  32'd1,          32'd0,          4'b1000, 1});
    vecs.push_back('{"lui_or",  2'b11, 3'd0, 7'h00, 32'h1234_5000,  32'h0000_0678,  32'h1234_5678,  4'b0110, 1});
    vecs.push_back('{"sll",     2'b01, 3'd1, 7'h00, 32'd1,          32'h23,         32'd8,          4'b0010, 1});
    vecs.push_back('{"div_neg", 2'b01, 3'd4, 7'h01, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  4'b1111, 34});
    vecs.push_back('{"rem_neg", 2'b01, 3'd6, 7'h01, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  4'b1111, 34});
    vecs.push_back('{"mul",     2'b01, 3'd0, 7'h01, 32'hFFFF_FFFD,  32'd5,          32'hFFFF_FFF1,  4'b1111, 34});
    vecs.push_back('{"mulhu",   2'b01, 3'd3, 7'h01, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'hFFFF_FFFE,  4'b1111, 34});
    vecs.push_back('{"mulhsu",  2'b01, 3'd2, 7'h01, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'hFFFF_FFFF,  4'b1111, 34});
    vecs.push_back('{"divu",    2'b01, 3'd5, 7'h01, 32'd100,        32'd7,          32'd14,         4'b1111, 34});

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    alu_op = '0; funct3 = '0; funct7 = '0; src_a = '0; src_b = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_result", 64'(result), 64'd0);
    check("rst_ctl", 64'(alu_control), 64'd0);
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);

    // Directed vector table.
    foreach (vecs[i]) begin
      run_op(vecs[i].name, vecs[i].op, vecs[i].f3, vecs[i].f7, vecs[i].a, vecs[i].b, r, c, lat, bcnt);
      check({vecs[i].name, "_result"}, 64'(r), 64'(vecs[i].res));
      check({vecs[i].name, "_ctl"}, 64'(c), 64'(vecs[i].ctl));
      check({vecs[i].name, "_latency"}, 64'(lat), 64'(vecs[i].lat));
      check({vecs[i].name, "_busy_cycles"}, 64'(bcnt), 64'((vecs[i].lat == 34) ? 33 : 0));
      ack(vecs[i].name);
    end

    // Backpressure: DIVU 100/7 held in DONE while another op is offered.
    run_op("bp", 2'b01, 3'd5, 7'h01, 32'd100, 32'd7, r, c, lat, bcnt);
    check("bp_latency", 64'(lat), 64'd34);
    alu_op = 2'b00; funct3 = 3'd0; funct7 = 7'h00; src_a = 32'd1; src_b = 32'd1;
    in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      check($sformatf("bp_hold%0d_result", k), 64'(result), 64'd14);
      check($sformatf("bp_hold%0d_out_valid", k), 64'(out_valid), 64'd1);
      check($sformatf("bp_hold%0d_in_ready", k), 64'(in_ready), 64'd0);
      @(negedge clk);
    end
    in_valid = 1'b0;
    ack("bp");
    @(negedge clk);
    check("bp_ignored_op", 64'(out_valid), 64'd0);

    // Reset in the middle of a DIVU iteration.
    alu_op = 2'b01; funct3 = 3'd5; funct7 = 7'h01; src_a = 32'd100; src_b = 32'd7;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (10) @(negedge clk);
    check("rstmid_busy_before", 64'(busy), 64'd1);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("rstmid_busy", 64'(busy), 64'd0);
    check("rstmid_out_valid", 64'(out_valid), 64'd0);
    check("rstmid_result", 64'(result), 64'd0);
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("rstmid_in_ready", 64'(in_ready), 64'd1);
    run_op("rstmid_add", 2'b00, 3'd0, 7'h00, 32'd20, 32'd22, r, c, lat, bcnt);
    check("rstmid_add_result", 64'(r), 64'd42);
    check("rstmid_add_latency", 64'(lat), 64'd1);
    ack("rstmid_add");

    // Randomized ops against the reference model.
    for (int i = 0; i < 250; i++) begin
      op = 2'($urandom_range(0, 3));
      f3 = 3'($urandom);
      if (op == 2'b10 && f3[2:1] == 2'b01) f3[1] = 1'b0;
      case ($urandom_range(0, 3))
        0:       f7 = 7'h00;
        1:       f7 = 7'h20;
        2:       f7 = 7'h01;
        default: f7 = 7'($urandom);
      endcase
      a = pick();
      b = pick();
      model(op, f3, f7, a, b, mr, mc, mlat);
      run_op($sformatf("rnd%0d", i), op, f3, f7, a, b, r, c, lat, bcnt);
      check($sformatf("rnd%0d_result op=%0d f3=%0d f7=%0h a=%0h b=%0h", i, op, f3, f7, a, b), 64'(r), 64'(mr));
      check($sformatf("rnd%0d_ctl", i), 64'(c), 64'(mc));
      check($sformatf("rnd%0d_latency", i), 64'(lat), 64'(mlat));
      ack($sformatf("rnd%0d", i));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
